// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM encoding and the
// baud divisor helper used by both the transmitter and the future receiver.
package uart_pkg;

    // Parity mode selector values
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Transmitter FSM encoding
    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Clock cycles per bit period; the fractional part is dropped.
    function automatic int div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer. Counts 0..BAUD_DIV-1 and wraps; tick is registered and
// high during the last cycle of each bit period. clear restarts the period
// so that the next bit period begins on the following cycle.
module uart_baud_gen #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Next count and the tick that marks the final cycle of the period
    always_comb begin
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        tick_d = (cnt_d == LAST);
    end

    // Counter and tick registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS payload (LSB first), optional odd
// or even parity, one or two stop bits, valid/ready input handshake.
//
// Handshake: a frame is transferred on a rising edge where tx_valid and
// tx_ready are both high; tx_data is captured at that edge. tx_ready is high
// only while idle, so tx_valid/tx_data are ignored for the rest of the frame.
// tx_ready rises together with the tx_done pulse, letting a source that keeps
// tx_valid high start the next frame after a single idle-high cycle.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 baud_tick
);

    localparam int         BAUD_DIV   = div(CLK_FREQ, BAUD_RATE);
    localparam bit         HAS_PARITY = (PARITY != PARITY_NONE);
    localparam logic [3:0] LAST_BIT   = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);

    // Reject configurations the frame logic cannot produce
    if (BAUD_DIV < 2) begin : g_bad_baud_div
        $error("uart_tx_cfg: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 parity_q, parity_d;
    logic                 tx_out_q, tx_out_d;
    logic                 tx_done_q, tx_done_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 tx_busy_q, tx_busy_d;

    logic                 xfer;
    logic                 bit_tick;
    logic                 par_calc;

    // A frame is accepted only while idle
    assign xfer = tx_valid && tx_ready_q;

    // Odd parity makes the total count of ones odd, even makes it even
    assign par_calc = (PARITY == PARITY_ODD) ? ~^tx_data : ^tx_data;

    // Bit period restarts on every accepted frame so the start bit is full length
    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (xfer),
        .tick  (bit_tick)
    );

    // Frame sequencing; the line value for the next bit is decided here so tx_out is a flop
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        parity_d   = parity_q;
        tx_out_d   = tx_out_q;
        tx_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_out_d = 1'b1;
                if (xfer) begin
                    shift_d    = tx_data;
                    parity_d   = par_calc;
                    bit_idx_d  = 4'd0;
                    stop_idx_d = 1'b0;
                    tx_out_d   = 1'b0;
                    state_d    = ST_START;
                end
            end

            ST_START: begin
                if (bit_tick) begin
                    tx_out_d = shift_q[0];
                    state_d  = ST_DATA;
                end
            end

            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        if (HAS_PARITY) begin
                            tx_out_d = parity_q;
                            state_d  = ST_PARITY;
                        end else begin
                            tx_out_d   = 1'b1;
                            stop_idx_d = 1'b0;
                            state_d    = ST_STOP;
                        end
                    end else begin
                        // shift_q[0] is on the line now; the next bit is shift_q[1]
                        tx_out_d  = shift_q[1];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end

            ST_PARITY: begin
                if (bit_tick) begin
                    tx_out_d   = 1'b1;
                    stop_idx_d = 1'b0;
                    state_d    = ST_STOP;
                end
            end

            ST_STOP: begin
                tx_out_d = 1'b1;
                if (bit_tick) begin
                    if (stop_idx_q == LAST_STOP) begin
                        tx_done_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end

            default: begin
                tx_out_d = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase

        tx_ready_d = (state_d == ST_IDLE);
        tx_busy_d  = ~tx_ready_d;
    end

    // State and registered outputs; reset idles the line high and drops any frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= 4'd0;
            stop_idx_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_out_q   <= 1'b1;
            tx_done_q  <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            parity_q   <= parity_d;
            tx_out_q   <= tx_out_d;
            tx_done_q  <= tx_done_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    assign tx_out    = tx_out_q;
    assign tx_done   = tx_done_q;
    assign tx_ready  = tx_ready_q;
    assign tx_busy   = tx_busy_q;
    assign baud_tick = bit_tick;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three instances (8N1, 8E1, 8O2) at BAUD_DIV=10.
// Line patterns are given as hand-computed constants, bit k = k-th line bit.
`timescale 1ns/1ps
module tb_uart_tx_cfg;
    import uart_pkg::*;

    localparam int CLK_FREQ  = 1000000;
    localparam int BAUD_RATE = 100000;
    localparam int BAUD_DIV  = 10;
    localparam int NV        = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // index 0 = 8N1, 1 = 8E1, 2 = 8O2
    logic [2:0] valid_v = 3'b000;
    logic [7:0] data_v [3];
    logic [2:0] out_v, ready_v, busy_v, done_v, tick_v;

    int errors = 0;
    int checks = 0;

    uart_tx_cfg #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8),
        .PARITY(PARITY_NONE), .STOP_BITS(1)
    ) dut_n (
        .clk(clk), .rst(rst), .tx_valid(valid_v[0]), .tx_ready(ready_v[0]),
        .tx_data(data_v[0]), .tx_out(out_v[0]), .tx_busy(busy_v[0]),
        .tx_done(done_v[0]), .baud_tick(tick_v[0])
    );

    uart_tx_cfg #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8),
        .PARITY(PARITY_EVEN), .STOP_BITS(1)
    ) dut_e (
        .clk(clk), .rst(rst), .tx_valid(valid_v[1]), .tx_ready(ready_v[1]),
        .tx_data(data_v[1]), .tx_out(out_v[1]), .tx_busy(busy_v[1]),
        .tx_done(done_v[1]), .baud_tick(tick_v[1])
    );

    uart_tx_cfg #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8),
        .PARITY(PARITY_ODD), .STOP_BITS(2)
    ) dut_o (
        .clk(clk), .rst(rst), .tx_valid(valid_v[2]), .tx_ready(ready_v[2]),
        .tx_data(data_v[2]), .tx_out(out_v[2]), .tx_busy(busy_v[2]),
        .tx_done(done_v[2]), .baud_tick(tick_v[2])
    );

    // ---------------- vector table ----------------
    typedef struct {
        int          sel;
        logic [7:0]  data;
        logic [11:0] exp;
        int          nbits;
    } vec_t;

    vec_t vecs [NV];

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge with the DUT idle; returns 1ns after the transfer edge.
    task automatic send(input int sel, input logic [7:0] d, input string name);
        chk($sformatf("%s ready before send", name), 32'(ready_v[sel]), 32'h1);
        valid_v[sel] = 1'b1;
        data_v[sel]  = d;
        @(posedge clk);
        #1 valid_v[sel] = 1'b0;
    endtask

    // Starts right after the transfer edge; ends at the negedge of the tx_done cycle.
    task automatic check_frame(input int sel, input logic [11:0] exp, input int nbits,
                               input string name);
        logic [9:0] lv, tv, dv, rv;
        for (int b = 0; b < nbits; b++) begin
            lv = '0; tv = '0; dv = '0; rv = '0;
            for (int j = 0; j < BAUD_DIV; j++) begin
                @(negedge clk);
                lv[j] = out_v[sel];
                tv[j] = tick_v[sel];
                dv[j] = done_v[sel];
                rv[j] = ready_v[sel];
            end
            chk($sformatf("%s line bit %0d", name, b), 32'(lv), exp[b] ? 32'h3FF : 32'h0);
            chk($sformatf("%s tick bit %0d", name, b), 32'(tv), 32'h200);
            chk($sformatf("%s done/ready bit %0d", name, b), 32'({dv, rv}), 32'h0);
        end
        @(negedge clk);
        chk($sformatf("%s end {done,ready,busy,out}", name),
            32'({done_v[sel], ready_v[sel], busy_v[sel], out_v[sel]}), 32'b1101);
    endtask

    // Watches n cycles on the 8N1 instance; line must stay high, idle, no tx_done.
    task automatic check_quiet(input int n, input string name);
        logic ok;
        ok = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (out_v[0] !== 1'b1 || done_v[0] !== 1'b0 || ready_v[0] !== 1'b1) ok = 1'b0;
        end
        chk(name, 32'(ok), 32'h1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{0, 8'hC5, 12'h38A, 10};
        vecs[1] = '{0, 8'h6A, 12'h2D4, 10};
        vecs[2] = '{0, 8'h00, 12'h200, 10};
        vecs[3] = '{0, 8'hFF, 12'h3FE, 10};
        vecs[4] = '{1, 8'hC5, 12'h58A, 11};
        vecs[5] = '{1, 8'h01, 12'h602, 11};
        vecs[6] = '{1, 8'h6A, 12'h4D4, 11};
        vecs[7] = '{2, 8'h6A, 12'hED4, 12};
        vecs[8] = '{2, 8'h00, 12'hE00, 12};
        vecs[9] = '{2, 8'hC5, 12'hF8A, 12};

        // Reset held with tx_valid high: everything idle, nothing accepted
        data_v[0] = 8'hA5; data_v[1] = 8'hA5; data_v[2] = 8'hA5;
        valid_v = 3'b111;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("reset cycle %0d {out,ready,busy,done,tick}", c),
                32'({out_v, ready_v, busy_v, done_v, tick_v}),
                32'({3'b111, 3'b111, 3'b000, 3'b000, 3'b000}));
        end
        valid_v = 3'b000;
        rst     = 1'b0;
        check_quiet(20, "post-reset idle");

        // Table: single frames on each configuration
        for (int i = 0; i < NV; i++) begin
            send(vecs[i].sel, vecs[i].data, $sformatf("vec%0d", i));
            check_frame(vecs[i].sel, vecs[i].exp, vecs[i].nbits, $sformatf("vec%0d", i));
            @(negedge clk);
            chk($sformatf("vec%0d done drops", i), 32'(done_v[vecs[i].sel]), 32'h0);
        end

        // Back-to-back: tx_valid held high, second start bit right after tx_done cycle
        chk("b2b ready", 32'(ready_v[0]), 32'h1);
        valid_v[0] = 1'b1;
        data_v[0]  = 8'hC5;
        @(posedge clk);
        #1 data_v[0] = 8'h6A;
        check_frame(0, 12'h38A, 10, "b2b first");
        @(posedge clk);
        #1 valid_v[0] = 1'b0;
        check_frame(0, 12'h2D4, 10, "b2b second");
        @(negedge clk);
        chk("b2b done drops", 32'(done_v[0]), 32'h0);

        // Input activity while busy must not disturb the frame
        send(0, 8'h0F, "busy");
        fork
            check_frame(0, 12'h21E, 10, "busy frame");
            begin
                repeat (25) @(negedge clk);
                valid_v[0] = 1'b1; data_v[0] = 8'hF0;
                @(negedge clk);
                valid_v[0] = 1'b0; data_v[0] = 8'h33;
                repeat (30) @(negedge clk);
                valid_v[0] = 1'b1; data_v[0] = 8'h00;
                repeat (5) @(negedge clk);
                valid_v[0] = 1'b0;
            end
        join
        check_quiet(120, "busy single done");

        // Reset during data bit 3: line high next edge, frame dropped, next frame intact
        send(0, 8'hC5, "abort");
        repeat (44) @(negedge clk);
        chk("abort line before reset", 32'(out_v[0]), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort after reset {out,ready,busy,done}",
            32'({out_v[0], ready_v[0], busy_v[0], done_v[0]}), 32'b1100);
        rst = 1'b0;
        check_quiet(120, "abort no done");
        send(0, 8'h55, "after abort");
        check_frame(0, 12'h2AA, 10, "after abort");
        @(negedge clk);
        chk("after abort done drops", 32'(done_v[0]), 32'h0);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
